// File: rtl/taxi_eth_gmii_phy_loopback.sv
// GMII PHY-side loopback: stores each whole frame from gmii_tx*
// and replays it on gmii_rx* with a programmable gap and rx_er injection.
module taxi_eth_gmii_phy_loopback #(
    parameter int FIFO_DEPTH = 4096,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       gmii_txd,
    input  logic             gmii_tx_en,
    input  logic             gmii_tx_er,
    output logic [7:0]       gmii_rxd,
    output logic             gmii_rx_dv,
    output logic             gmii_rx_er,
    input  logic             cfg_enable,
    input  logic [7:0]       cfg_ifg,
    input  logic             cfg_err_inject,
    input  logic [15:0]      cfg_err_offset,
    output logic             stat_frame_rx,
    output logic             stat_frame_tx,
    output logic             stat_drop_overflow,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_SEND, RD_GAP} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [8:0] hold_q, hold_d;
    logic ovf_q, ovf_d;
    logic tx_en_prev_q, tx_en_prev_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic stat_rx_q, stat_rx_d;
    logic stat_drop_q, stat_drop_d;

    logic arm_q, arm_d;
    logic act_q, act_d;
    logic [15:0] off_q, off_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] rxd_q, rxd_d;
    logic rx_dv_q, rx_dv_d;
    logic rx_er_q, rx_er_d;
    logic stat_tx_q, stat_tx_d;

    // entry = {last, er, data}
    logic [9:0] mem [FIFO_DEPTH];
    logic [9:0] mem_q;
    logic mem_we;
    logic [9:0] mem_wd;
    logic full;

    assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

    // write side: one-byte holding register so the final byte can be tagged last
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        hold_d       = hold_q;
        ovf_d        = ovf_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        stat_rx_d    = 1'b0;
        stat_drop_d  = 1'b0;
        mem_we       = 1'b0;
        mem_wd       = {1'b0, hold_q};
        tx_en_prev_d = gmii_tx_en;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (gmii_tx_en && !tx_en_prev_q) begin
                    if (cfg_enable) begin
                        hold_d     = {gmii_tx_er, gmii_txd};
                        wr_state_d = WR_FRAME;
                    end else begin
                        ovf_d      = 1'b0;
                        wr_state_d = WR_DROP;
                    end
                end
            end
            WR_FRAME: begin
                if (full) begin
                    wr_ptr_d = commit_ptr_q;
                    if (gmii_tx_en) begin
                        ovf_d      = 1'b1;
                        wr_state_d = WR_DROP;
                    end else begin
                        stat_drop_d = 1'b1;
                        drop_cnt_d  = drop_cnt_q + CNT_ONE;
                        wr_state_d  = WR_IDLE;
                    end
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (gmii_tx_en) begin
                        hold_d = {gmii_tx_er, gmii_txd};
                    end else begin
                        mem_wd       = {1'b1, hold_q};
                        commit_ptr_d = wr_ptr_q + PTR_ONE;
                        stat_rx_d    = 1'b1;
                        frame_cnt_d  = frame_cnt_q + CNT_ONE;
                        wr_state_d   = WR_IDLE;
                    end
                end
            end
            WR_DROP: begin
                if (!gmii_tx_en) begin
                    if (ovf_q) begin
                        stat_drop_d = 1'b1;
                        drop_cnt_d  = drop_cnt_q + CNT_ONE;
                    end
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // read side: mem_q always holds mem[rd_ptr_q], so bytes stream back to back
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        arm_d      = arm_q | cfg_err_inject;
        act_d      = act_q;
        off_d      = off_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        rxd_d      = 8'd0;
        rx_dv_d    = 1'b0;
        rx_er_d    = 1'b0;
        stat_tx_d  = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (commit_ptr_q != rd_ptr_q) begin
                    act_d      = arm_q;
                    arm_d      = cfg_err_inject;
                    off_d      = cfg_err_offset;
                    idx_d      = 16'd0;
                    rd_state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                rxd_d    = mem_q[7:0];
                rx_dv_d  = 1'b1;
                rx_er_d  = mem_q[8] | (act_q && (idx_q == off_q));
                idx_d    = idx_q + 16'd1;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (mem_q[9]) begin
                    stat_tx_d = 1'b1;
                    if (cfg_ifg <= 8'd1) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        gap_d      = cfg_ifg - 8'd1;
                        rd_state_d = RD_GAP;
                    end
                end
            end
            RD_GAP: begin
                if (gap_q <= 8'd1) begin
                    rd_state_d = RD_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // frame buffer with registered read
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= mem_wd;
        end
        mem_q <= mem[rd_ptr_d[AW-1:0]];
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= WR_IDLE;
            rd_state_q   <= RD_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            ovf_q        <= 1'b0;
            tx_en_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            stat_rx_q    <= 1'b0;
            stat_drop_q  <= 1'b0;
            arm_q        <= 1'b0;
            act_q        <= 1'b0;
            off_q        <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            rxd_q        <= '0;
            rx_dv_q      <= 1'b0;
            rx_er_q      <= 1'b0;
            stat_tx_q    <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_q       <= hold_d;
            ovf_q        <= ovf_d;
            tx_en_prev_q <= tx_en_prev_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            stat_rx_q    <= stat_rx_d;
            stat_drop_q  <= stat_drop_d;
            arm_q        <= arm_d;
            act_q        <= act_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            rxd_q        <= rxd_d;
            rx_dv_q      <= rx_dv_d;
            rx_er_q      <= rx_er_d;
            stat_tx_q    <= stat_tx_d;
        end
    end

    assign gmii_rxd           = rxd_q;
    assign gmii_rx_dv         = rx_dv_q;
    assign gmii_rx_er         = rx_er_q;
    assign stat_frame_rx      = stat_rx_q;
    assign stat_frame_tx      = stat_tx_q;
    assign stat_drop_overflow = stat_drop_q;
    assign frame_cnt          = frame_cnt_q;
    assign drop_cnt           = drop_cnt_q;
endmodule
